// File: rtl/octree_pkg.sv
// Shared types for the octree node SRAM access path.
package octree_pkg;

    // Arbiter ownership state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_S = 2'd1,
        OWN_U = 2'd2
    } arb_state_e;

    // Identity of the requester that last held the SRAM
    typedef enum logic {
        OWN_SEARCHER = 1'b0,
        OWN_UPDATER  = 1'b1
    } owner_e;

    // Controller operation codes
    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SEARCH = 2'd1,
        ADD    = 2'd2,
        DEL    = 2'd3
    } ctrl_op_e;

    // Legacy static memory-select codes
    typedef enum logic [1:0] {
        NAN      = 2'd0,
        SEARCHER = 2'd1,
        UPDATER  = 2'd2
    } mem_sel_e;

    // Width of the optional stall counters
    localparam int unsigned STALL_W = 16;

    // The requester opposite to o
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_SEARCHER) ? OWN_UPDATER : OWN_SEARCHER;
    endfunction

endpackage

// File: rtl/octree_arb_rr2.sv
// Two-way round-robin picker: on a tie the requester that did not own last wins.
module octree_arb_rr2
    import octree_pkg::*;
(
    input  logic   req_s,
    input  logic   req_u,
    input  owner_e last_owner,
    output owner_e winner_c
);

    // Tie goes to the non-last owner; a lone requester always wins
    always_comb begin
        winner_c = OWN_SEARCHER;
        if (req_s && req_u) begin
            winner_c = other_owner(last_owner);
        end else if (req_u) begin
            winner_c = OWN_UPDATER;
        end
    end

endmodule

// File: rtl/octree_sram_arbiter.sv
// Round-robin arbiter sharing the single-port octree node SRAM between the
// searcher (s_*) and the updater (u_*), with bounded lockable bursts.
// Optional macro OCT_ARB_STATS_EN adds per-requester saturating stall counters.
module octree_sram_arbiter
    import octree_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s_req,
    input  logic                  s_we,
    input  logic                  s_lock,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    output logic                  s_gnt,
    output logic                  s_rvalid,
    output logic [DATA_WIDTH-1:0] s_rdata,

    input  logic                  u_req,
    input  logic                  u_we,
    input  logic                  u_lock,
    input  logic [ADDR_WIDTH-1:0] u_addr,
    input  logic [DATA_WIDTH-1:0] u_wdata,
    output logic                  u_gnt,
    output logic                  u_rvalid,
    output logic [DATA_WIDTH-1:0] u_rdata,

`ifdef OCT_ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [STALL_W-1:0]    s_stall_cnt,
    output logic [STALL_W-1:0]    u_stall_cnt,
`endif

    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e       state, state_nxt;
    owner_e           last_owner, last_nxt;
    owner_e           pick_c;
    logic [CNT_W-1:0] beat_cnt, cnt_nxt;

    logic acc_s, acc_u;
    logic own_req, own_lock, own_acc, oth_req;
    logic burst_full, rel;

    assign acc_s = s_req && s_gnt;
    assign acc_u = u_req && u_gnt;

    // Tie-break used when leaving IDLE
    octree_arb_rr2 u_rr2 (
        .req_s      (s_req),
        .req_u      (u_req),
        .last_owner (last_owner),
        .winner_c   (pick_c)
    );

    // State, burst counter, grants and read-return flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= OWN_UPDATER;
            beat_cnt   <= '0;
            s_gnt      <= 1'b0;
            u_gnt      <= 1'b0;
            s_rvalid   <= 1'b0;
            u_rvalid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_nxt;
            beat_cnt   <= cnt_nxt;
            s_gnt      <= (state_nxt == OWN_S);
            u_gnt      <= (state_nxt == OWN_U);
            s_rvalid   <= acc_s && !s_we;
            u_rvalid   <= acc_u && !u_we;
        end
    end

    // Next ownership: release on idle, unlocked beat, or full burst under contention
    always_comb begin
        state_nxt  = state;
        last_nxt   = last_owner;
        cnt_nxt    = beat_cnt;
        own_req    = 1'b0;
        own_lock   = 1'b0;
        own_acc    = 1'b0;
        oth_req    = 1'b0;
        rel        = 1'b0;
        burst_full = (beat_cnt == CNT_LAST);

        case (state)
            IDLE: begin
                if (s_req || u_req) begin
                    state_nxt = (pick_c == OWN_SEARCHER) ? OWN_S : OWN_U;
                end
                cnt_nxt = '0;
            end
            OWN_S, OWN_U: begin
                if (state == OWN_S) begin
                    own_req  = s_req;
                    own_lock = s_lock;
                    own_acc  = acc_s;
                    oth_req  = u_req;
                end else begin
                    own_req  = u_req;
                    own_lock = u_lock;
                    own_acc  = acc_u;
                    oth_req  = s_req;
                end

                rel = !own_req
                   || (own_acc && !own_lock)
                   || (own_acc && burst_full && oth_req);

                if (rel) begin
                    cnt_nxt  = '0;
                    last_nxt = (state == OWN_S) ? OWN_SEARCHER : OWN_UPDATER;
                    if (oth_req) begin
                        state_nxt = (state == OWN_S) ? OWN_U : OWN_S;
                    end else if (own_req && own_lock) begin
                        state_nxt = state;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (own_acc && !burst_full) begin
                    cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // SRAM port driven straight from the accepted beat; quiet otherwise
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (acc_s) begin
            sram_ce    = 1'b1;
            sram_we    = s_we;
            sram_addr  = s_addr;
            sram_wdata = s_wdata;
        end else if (acc_u) begin
            sram_ce    = 1'b1;
            sram_we    = u_we;
            sram_addr  = u_addr;
            sram_wdata = u_wdata;
        end
    end

    // Read data steered to whichever requester issued the read last cycle
    always_comb begin
        s_rdata = s_rvalid ? sram_rdata : '0;
        u_rdata = u_rvalid ? sram_rdata : '0;
    end

`ifdef OCT_ARB_STATS_EN
    // Saturating count of cycles each requester waited without a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_stall_cnt <= '0;
            u_stall_cnt <= '0;
        end else if (stats_clr) begin
            s_stall_cnt <= '0;
            u_stall_cnt <= '0;
        end else begin
            if (s_req && !s_gnt && (s_stall_cnt != {STALL_W{1'b1}})) begin
                s_stall_cnt <= s_stall_cnt + STALL_W'(1);
            end
            if (u_req && !u_gnt && (u_stall_cnt != {STALL_W{1'b1}})) begin
                u_stall_cnt <= u_stall_cnt + STALL_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_octree_sram_arbiter.sv
// Bench for octree_sram_arbiter: directed tables, hand sequences and a random
// phase, all checked against a transaction-level reference model.
module tb_octree_sram_arbiter;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_req, s_we, s_lock, u_req, u_we, u_lock;
    logic [AW-1:0] s_addr, u_addr;
    logic [DW-1:0] s_wdata, u_wdata;
    logic          s_gnt, s_rvalid, u_gnt, u_rvalid;
    logic [DW-1:0] s_rdata, u_rdata;
    logic          sram_ce, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
`ifdef OCT_ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   s_stall_cnt, u_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    octree_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req(s_req), .s_we(s_we), .s_lock(s_lock), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .u_req(u_req), .u_we(u_we), .u_lock(u_lock), .u_addr(u_addr), .u_wdata(u_wdata),
        .u_gnt(u_gnt), .u_rvalid(u_rvalid), .u_rdata(u_rdata),
`ifdef OCT_ARB_STATS_EN
        .stats_clr(stats_clr), .s_stall_cnt(s_stall_cnt), .u_stall_cnt(u_stall_cnt),
`endif
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Background content of a never-written word
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 64'hA5A5_0000_0000_0000 | (64'(a) * 64'h0000_0001_0001);
    endfunction

    // SRAM behavioural model, 1-cycle read latency
    logic [DW-1:0] mem [int];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[int'(sram_addr)] = sram_wdata;
            else sram_rdata <= mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : pat(sram_addr);
        end
    end

    // ---------------- reference model (transaction level) ----------------
    // owner: 0 nobody, 1 searcher, 2 updater; held = beats taken in current tenure
    int            m_owner, m_last, m_held;
    bit            m_rvs, m_rvu;
    logic [DW-1:0] m_rds, m_rdu;
    int            m_stall_s, m_stall_u;
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
    endfunction

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_held = 0;
        m_rvs = 0; m_rvu = 0; m_rds = '0; m_rdu = '0;
        m_stall_s = 0; m_stall_u = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output with the model, then move the model one cycle on
    task automatic model_step();
        bit gs, gu, as, au, xr, xl, orq;
        gs = (m_owner == 1); gu = (m_owner == 2);
        as = s_req && gs;    au = u_req && gu;
        chk("s_gnt", 64'(s_gnt), 64'(gs));
        chk("u_gnt", 64'(u_gnt), 64'(gu));
        chk("sram_ce", 64'(sram_ce), 64'(as || au));
        chk("sram_we", 64'(sram_we), as ? 64'(s_we) : au ? 64'(u_we) : 64'd0);
        chk("sram_addr", 64'(sram_addr), as ? 64'(s_addr) : au ? 64'(u_addr) : 64'd0);
        chk("sram_wdata", sram_wdata, as ? s_wdata : au ? u_wdata : 64'd0);
        chk("s_rvalid", 64'(s_rvalid), 64'(m_rvs));
        chk("u_rvalid", 64'(u_rvalid), 64'(m_rvu));
        chk("s_rdata", s_rdata, m_rvs ? m_rds : 64'd0);
        chk("u_rdata", u_rdata, m_rvu ? m_rdu : 64'd0);
`ifdef OCT_ARB_STATS_EN
        chk("s_stall_cnt", 64'(s_stall_cnt), 64'(m_stall_s));
        chk("u_stall_cnt", 64'(u_stall_cnt), 64'(m_stall_u));
        if (stats_clr) begin
            m_stall_s = 0; m_stall_u = 0;
        end else begin
            if (s_req && !gs && m_stall_s < 65535) m_stall_s++;
            if (u_req && !gu && m_stall_u < 65535) m_stall_u++;
        end
`endif
        // memory traffic
        m_rvs = as && !s_we; m_rvu = au && !u_we;
        if (as && !s_we) m_rds = ref_rd(s_addr);
        if (au && !u_we) m_rdu = ref_rd(u_addr);
        if (as && s_we) ref_mem[int'(s_addr)] = s_wdata;
        if (au && u_we) ref_mem[int'(u_addr)] = u_wdata;
        // ownership
        if (m_owner == 0) begin
            if (s_req && u_req) m_owner = 3 - m_last;
            else if (s_req)     m_owner = 1;
            else if (u_req)     m_owner = 2;
            m_held = 0;
        end else begin
            xr  = (m_owner == 1) ? s_req  : u_req;
            xl  = (m_owner == 1) ? s_lock : u_lock;
            orq = (m_owner == 1) ? u_req  : s_req;
            if (!xr || !xl || (m_held >= MB - 1 && orq)) begin
                m_last  = m_owner;
                m_owner = orq ? 3 - m_owner : 0;
                m_held  = 0;
            end else begin
                m_held++;
            end
        end
    endtask

    // Snapshot of DUT outputs at the sample point of the current cycle
    logic          sn_sg, sn_ug, sn_srv, sn_urv;
    logic [DW-1:0] sn_srd;
    logic [15:0]   sn_ust;

    task automatic settle();
        #1;
        sn_sg = s_gnt; sn_ug = u_gnt; sn_srv = s_rvalid; sn_urv = u_rvalid; sn_srd = s_rdata;
`ifdef OCT_ARB_STATS_EN
        sn_ust = u_stall_cnt;
`else
        sn_ust = '0;
`endif
    endtask

    task automatic finish_cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        finish_cycle();
    endtask

    task automatic idle_inputs();
        s_req = 0; s_we = 0; s_lock = 0; s_addr = '0; s_wdata = '0;
        u_req = 0; u_we = 0; u_lock = 0; u_addr = '0; u_wdata = '0;
`ifdef OCT_ARB_STATS_EN
        stats_clr = 0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_s_gnt", 64'(s_gnt), 64'd0);
        chk("rst_u_gnt", 64'(u_gnt), 64'd0);
        chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_u_rvalid", 64'(u_rvalid), 64'd0);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst_before;
        logic        s_req, s_lock;
        logic [11:0] s_addr;
        logic        u_req, u_lock;
        logic [11:0] u_addr;
        logic        e_sg, e_ug, e_ce;
        logic [11:0] e_addr;
        logic        e_srv;
    } vec_t;

    vec_t vt [$];

    initial begin
        int first_u, s_run, s_cnt, u_cnt;
        bit u_rv_seen;

        // single searcher read of 0x010
        vt.push_back('{1, 1, 0, 12'h010, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0});
        vt.push_back('{0, 1, 0, 12'h010, 0, 0, 12'h000, 1, 0, 1, 12'h010, 0});
        vt.push_back('{0, 0, 0, 12'h010, 0, 0, 12'h000, 0, 0, 0, 12'h000, 1});
        // both request single beats: strict alternation starting with S
        vt.push_back('{1, 1, 0, 12'h100, 1, 0, 12'h200, 0, 0, 0, 12'h000, 0});
        vt.push_back('{0, 1, 0, 12'h100, 1, 0, 12'h200, 1, 0, 1, 12'h100, 0});
        vt.push_back('{0, 1, 0, 12'h100, 1, 0, 12'h200, 0, 1, 1, 12'h200, 1});
        vt.push_back('{0, 1, 0, 12'h100, 1, 0, 12'h200, 1, 0, 1, 12'h100, 0});
        vt.push_back('{0, 1, 0, 12'h100, 1, 0, 12'h200, 0, 1, 1, 12'h200, 1});
        vt.push_back('{0, 1, 0, 12'h100, 1, 0, 12'h200, 1, 0, 1, 12'h100, 0});
        vt.push_back('{0, 1, 0, 12'h100, 1, 0, 12'h200, 0, 1, 1, 12'h200, 1});
        vt.push_back('{0, 0, 0, 12'h100, 0, 0, 12'h200, 1, 0, 0, 12'h000, 0});

        rst_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);

        s_cnt = 0; u_cnt = 0;
        foreach (vt[i]) begin
            if (vt[i].rst_before) do_reset();
            s_req = vt[i].s_req; s_lock = vt[i].s_lock; s_addr = vt[i].s_addr; s_we = 0;
            u_req = vt[i].u_req; u_lock = vt[i].u_lock; u_addr = vt[i].u_addr; u_we = 0;
            settle();
            chk($sformatf("vec%0d_s_gnt", i), 64'(s_gnt), 64'(vt[i].e_sg));
            chk($sformatf("vec%0d_u_gnt", i), 64'(u_gnt), 64'(vt[i].e_ug));
            chk($sformatf("vec%0d_ce", i), 64'(sram_ce), 64'(vt[i].e_ce));
            chk($sformatf("vec%0d_addr", i), 64'(sram_addr), 64'(vt[i].e_addr));
            chk($sformatf("vec%0d_s_rvalid", i), 64'(s_rvalid), 64'(vt[i].e_srv));
            if (i >= 3) begin
                if (s_gnt && s_req) s_cnt++;
                if (u_gnt && u_req) u_cnt++;
            end
            finish_cycle();
        end
        chk("alt_s_beats", 64'(s_cnt), 64'd3);
        chk("alt_u_beats", 64'(u_cnt), 64'd3);

        // locked S burst vs continuous U: S capped at MB beats, U on cycle 9
        do_reset();
        first_u = -1; s_run = 0;
        for (int c = 0; c < 14; c++) begin
            s_req = 1; s_lock = 1; s_we = 0; s_addr = 12'h020 + 12'(c);
            u_req = (c >= 1); u_lock = 0; u_we = 0; u_addr = 12'h300;
            settle();
            if (c == 9) chk("burst_u_stall_cnt_8", 64'(sn_ust), 64'(`ifdef OCT_ARB_STATS_EN 8 `else 0 `endif));
            if (sn_ug && first_u < 0) first_u = c;
            if (sn_sg && first_u < 0) s_run++;
            if (c == 10) chk("burst_s_resumes", 64'(sn_sg), 64'd1);
            finish_cycle();
        end
        chk("burst_first_u_cycle", 64'(first_u), 64'd9);
        chk("burst_s_beats", 64'(s_run), 64'(MB));
`ifdef OCT_ARB_STATS_EN
        stats_clr = 1;
        cycle();
        stats_clr = 0;
        cycle();
        chk("stats_clr_u", 64'(sn_ust), 64'd0);
`endif

        // U writes 0x3FF then S reads it back; updater never gets rvalid
        do_reset();
        u_rv_seen = 0;
        u_req = 1; u_we = 1; u_lock = 0; u_addr = 12'h3FF; u_wdata = 64'h0000_0000_DEAD_BEEF;
        cycle(); u_rv_seen |= sn_urv;
        s_req = 1; s_we = 0; s_lock = 0; s_addr = 12'h3FF;
        cycle(); u_rv_seen |= sn_urv;
        u_req = 0;
        cycle(); u_rv_seen |= sn_urv;
        s_req = 0;
        settle(); u_rv_seen |= sn_urv;
        chk("raw_s_rvalid", 64'(sn_srv), 64'd1);
        chk("raw_s_rdata", sn_srd, 64'h0000_0000_DEAD_BEEF);
        finish_cycle();
        cycle(); u_rv_seen |= sn_urv;
        chk("raw_no_u_rvalid", 64'(u_rv_seen), 64'd0);

        // asynchronous reset at beat 4 of a locked S burst
        do_reset();
        for (int c = 0; c < 5; c++) begin
            s_req = 1; s_lock = 1; s_we = 0; s_addr = 12'h040 + 12'(c);
            cycle();
        end
        settle();
        chk("pre_rst_s_gnt", 64'(sn_sg), 64'd1);
        chk("pre_rst_s_rvalid", 64'(sn_srv), 64'd1);
        rst_n = 0;
        #1;
        chk("async_rst_s_gnt", 64'(s_gnt), 64'd0);
        chk("async_rst_s_rvalid", 64'(s_rvalid), 64'd0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        s_req = 1; u_req = 1; s_addr = 12'h050; u_addr = 12'h060;
        rst_n = 1;
        cycle();
        cycle();
        chk("post_rst_tie_s", 64'(sn_sg), 64'd1);
        chk("post_rst_tie_u", 64'(sn_ug), 64'd0);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            s_req   = ($urandom_range(0, 3) != 0);
            s_we    = ($urandom_range(0, 2) == 0);
            s_lock  = ($urandom_range(0, 4) < 3);
            s_addr  = 12'($urandom_range(0, 15));
            s_wdata = {$urandom, $urandom};
            u_req   = ($urandom_range(0, 3) != 0);
            u_we    = ($urandom_range(0, 1) == 0);
            u_lock  = ($urandom_range(0, 4) < 3);
            u_addr  = 12'($urandom_range(0, 15));
            u_wdata = {$urandom, $urandom};
`ifdef OCT_ARB_STATS_EN
            stats_clr = ($urandom_range(0, 31) == 0);
`endif
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/octree_sram_arbiter.md
Name: octree_sram_arbiter

Overview:
Dynamic arbiter sharing the single-port octree node SRAM between the searcher (requester S) and the updater (requester U, add/delete anchor).
- Replaces a static mem_select mux so search and update traffic can interleave.
- Round-robin arbitration with bounded lockable bursts.
- Routes 1-cycle-latency read data back to the owning requester.

Parameters:
ADDR_WIDTH, 12, SRAM word address width
DATA_WIDTH, 64, SRAM word width (one octree node record)
MAX_BURST, 8, max beats one owner may hold while the other requester waits (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_req  in  1  searcher beat request
s_we  in  1  searcher write enable (0 = read)
s_lock  in  1  searcher wants to keep the grant after this beat
s_addr  in  ADDR_WIDTH  searcher address
s_wdata  in  DATA_WIDTH  searcher write data
s_gnt  out  1  searcher owns the SRAM this cycle
s_rvalid  out  1  searcher read data valid
s_rdata  out  DATA_WIDTH  searcher read data
u_req, u_we, u_lock, u_addr, u_wdata, u_gnt, u_rvalid, u_rdata: same as s_*, for the updater
sram_ce  out  1  SRAM chip enable
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_WIDTH  SRAM address
sram_wdata  out  DATA_WIDTH  SRAM write data
sram_rdata  in  DATA_WIDTH  SRAM read data, valid 1 cycle after a read ce

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk.
- Reset values: state IDLE, s_gnt = u_gnt = 0, s_rvalid = u_rvalid = 0, beat_cnt = 0, last_owner = U (so S wins the first tie).
- Reset mid-burst drops the grant immediately. Any pending rvalid is lost. Requesters must reissue.
- FSM states: IDLE, OWN_S, OWN_U. x_gnt is a registered decode: x_gnt = 1 iff state == OWN_x.
- Beat accepted for x: x_req && x_gnt.
  - On acceptance, sram_ce = 1 and sram_we/addr/wdata come combinationally from x.
  - With no accepted beat: sram_ce = 0, sram_we = 0, addr and wdata hold 0.
- Arbitration latency: a request seen in IDLE is granted the next cycle.
  - One requester only: grant it.
  - Both requesting: grant the one that is not last_owner.
- In OWN_x, each accepted beat increments beat_cnt.
- Release condition:
  - (a) x_req = 0 this cycle; or
  - (b) beat accepted and x_lock = 0; or
  - (c) beat accepted and beat_cnt == MAX_BURST-1, while the other requester is requesting.
- On release:
  - Other requester requesting: go directly to OWN_other (no bubble).
  - Else if x_req && x_lock: stay in OWN_x.
  - Else: IDLE.
  - beat_cnt clears on every release and on every ownership change. last_owner = x.
- Case (c) with the other requester idle: no forced release. beat_cnt saturates at MAX_BURST-1.
- Read return: x_rvalid is registered high exactly 1 cycle after x's accepted read. x_rdata = sram_rdata when x_rvalid, else 0.
- A read on the last beat before a handover still returns to the original owner.
- Writes produce no rvalid.
- Simultaneous S and U requests in IDLE alternate strictly, one grant at a time.

Optional Feature:
Macro OCT_ARB_STATS_EN.
- Defined: adds outputs s_stall_cnt and u_stall_cnt, 16 bits each, saturating at 0xFFFF, reset 0. A counter increments each cycle its requester has x_req = 1 and x_gnt = 0. Adds input stats_clr (synchronous clear, priority over increment).
- Undefined: these ports and the counters are absent.

Decomposition:
- Package octree_pkg holds:
  - arb_state_e {IDLE, OWN_S, OWN_U}
  - owner_e {OWN_SEARCHER, OWN_UPDATER}
  - CTRL op codes WAIT = 0, SEARCH = 1, ADD = 2, DEL = 3
  - mem-select codes NAN = 0, SEARCHER = 1, UPDATER = 2
- One natural sub-module: octree_arb_rr2, the 2-way round-robin picker (inputs req pair and last_owner; output winner). Everything else stays inline.

Test Plan:
- Reset, then s_req = 1 alone, read at addr 0x010 -> s_gnt high the next cycle; sram_ce = 1 with addr 0x010; s_rvalid high 1 cycle later with s_rdata = model data; u_gnt stays 0.
- S and U both request single beats (lock = 0) for 6 cycles -> grants alternate S, U, S, U… with no idle gap; beat counts equal (3/3).
- S locks a 20-beat read burst while U requests continuously -> S holds exactly MAX_BURST = 8 beats, U granted on cycle 9 with no bubble, then S resumes.
- U write 0xDEAD_BEEF to 0x3FF immediately followed by S read of 0x3FF -> S reads 0xDEAD_BEEF; no u_rvalid is ever asserted.
- Deassert rst_n mid S burst (beat 4) -> gnt and rvalid drop to 0 asynchronously. After release, an S+U tie is granted to S.
- OCT_ARB_STATS_EN defined, U blocked 8 cycles by an S burst -> u_stall_cnt = 8; stats_clr -> 0; forced overflow holds at 0xFFFF.
